// File: rtl/counter_run_controller.sv
// Start/pause/stop sequencer for a WIDTH-bit up-counter with terminal-count done pulse.
// Define PRESCALE_EN to advance the count once every PRESCALE clocks instead of every clock.
module counter_run_controller #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("PRESCALE must be at least 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic tick;
    logic at_limit;
    logic begin_run;
    logic run_step;

    assign at_limit  = (count_q == limit_q);
    assign begin_run = !stop && start && ((state_q == StIdle) || (state_q == StDone));
    // A pause in the same cycle as a tick swallows that tick.
    assign run_step  = !stop && !pause && (state_q == StRun);

`ifdef PRESCALE_EN
    localparam int unsigned PscW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PscW-1:0] PscMax = PscW'(PRESCALE - 1);

    logic [PscW-1:0] psc_q, psc_d;

    assign tick = (psc_q == PscMax);

    always_comb begin
        psc_d = psc_q;
        if (stop || begin_run) begin
            psc_d = '0;
        end else if (run_step) begin
            psc_d = tick ? '0 : psc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop outranks start, which outranks pause
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (!stop && start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (pause) begin
                    state_d = StPause;
                end else if (tick && at_limit && !auto_reload) begin
                    state_d = StDone;
                end
            end
            StPause: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (!pause) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Count and latched limit
    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        if (stop) begin
            count_d = '0;
        end else if (begin_run) begin
            count_d = '0;
            limit_d = limit;
        end else if (run_step && tick) begin
            if (!at_limit) begin
                count_d = count_q + 1'b1;
            end else if (auto_reload) begin
                count_d = '0;
            end
        end
    end

    // Registered outputs
    always_comb begin
        done_d = run_step && tick && at_limit;
        busy_d = (state_d == StRun) || (state_d == StPause);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            limit_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign busy  = busy_q;
    assign done  = done_q;

    a_count_within_limit : assert property (
        @(posedge clk) disable iff (!reset_n) count_q <= limit_q
    );

endmodule

// File: tb/tb_counter_run_controller.sv
// Bench for counter_run_controller: directed scenarios plus random stimulus,
// every cycle compared against an integer-level behavioural model.
module tb_counter_run_controller;

    localparam int W = 4;
    localparam int P = 4;
`ifdef PRESCALE_EN
    localparam int TK = P;
`else
    localparam int TK = 1;
`endif
    localparam int SIdle  = 0;
    localparam int SRun   = 1;
    localparam int SPause = 2;
    localparam int SDone  = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         pause = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] count;
    logic [1:0]   state;
    logic         busy;
    logic         done;

    counter_run_controller #(
        .WIDTH   (W),
        .PRESCALE(P)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .auto_reload(auto_reload),
        .limit      (limit),
        .count      (count),
        .state      (state),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: state code, count, latched limit, done pulse, cycles since last tick
    int m_state, m_count, m_limit, m_done, m_phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = SIdle;
        m_count = 0;
        m_limit = 0;
        m_done  = 0;
        m_phase = 0;
    endtask

    task automatic model_step();
        int  ns, nc, nl, np;
        bit  tick;
        ns = m_state;
        nc = m_count;
        nl = m_limit;
        np = m_phase;
        tick = ((m_phase + 1) % TK) == 0;
        m_done = 0;
        if (stop) begin
            ns = SIdle;
            nc = 0;
            np = 0;
        end else if ((m_state == SIdle || m_state == SDone) && start) begin
            ns = SRun;
            nc = 0;
            nl = int'(limit);
            np = 0;
        end else if (m_state == SRun && pause) begin
            ns = SPause;
        end else if (m_state == SRun) begin
            np = tick ? 0 : m_phase + 1;
            if (tick) begin
                if (m_count < m_limit) begin
                    nc = m_count + 1;
                end else begin
                    m_done = 1;
                    if (auto_reload) nc = 0;
                    else ns = SDone;
                end
            end
        end else if (m_state == SPause && !pause) begin
            ns = SRun;
        end
        m_state = ns;
        m_count = nc;
        m_limit = nl;
        m_phase = np;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".count"}, count, m_count);
        check({tag, ".state"}, state, m_state);
        check({tag, ".busy"}, busy, (m_state == SRun || m_state == SPause) ? 1 : 0);
        check({tag, ".done"}, done, m_done);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic begin_run(input int lim, input bit reload);
        limit       = W'(lim);
        auto_reload = reload;
        start       = 1'b1;
        cycle("start");
        start       = 1'b0;
    endtask

    int pulses;
    int k;

    initial begin
        model_reset();
        #7;
        check_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Asynchronous reset while running at count 5
        begin_run(9, 1'b0);
        k = 0;
        while (count != 5 && k < 100) begin
            cycle("t1");
            k++;
        end
        check("t1_reach5", count, 5);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t1_async");
        @(negedge clk);
        reset_n = 1'b1;

        // Single run to limit 3
        begin_run(3, 1'b0);
        pulses = 0;
        repeat (6 * TK) begin
            cycle("t2");
            if (done === 1'b1) pulses++;
        end
        check("t2_done_pulses", pulses, 1);
        check("t2_hold", count, 3);
        check("t2_state", state, SDone);

        // Auto-reload at limit 2, restarted from DONE
        begin_run(2, 1'b1);
        pulses = 0;
        repeat (9 * TK) begin
            cycle("t3");
            check("t3_busy", busy, 1);
            if (done === 1'b1) pulses++;
        end
        check("t3_done_pulses", pulses, 3);
        stop = 1'b1;
        cycle("t3_stop");
        stop = 1'b0;

        // Pause at count 2 for four cycles
        begin_run(9, 1'b0);
        k = 0;
        while (count != 2 && k < 100) begin
            cycle("t4");
            k++;
        end
        check("t4_reach2", count, 2);
        pause = 1'b1;
        repeat (4) begin
            cycle("t4_pause");
            check("t4_frozen", count, 2);
            check("t4_pstate", state, SPause);
        end
        pause = 1'b0;
        repeat (1 + TK) cycle("t4_resume");
        check("t4_resumed", count, 3);

        // Start and stop together in IDLE; stop from PAUSE
        stop = 1'b1;
        cycle("t5_stop");
        start = 1'b1;
        cycle("t5_both");
        check("t5_idle", state, SIdle);
        stop  = 1'b0;
        start = 1'b0;
        begin_run(7, 1'b0);
        pause = 1'b1;
        cycle("t5_pause");
        stop = 1'b1;
        cycle("t5_pstop");
        check("t5_pstop_count", count, 0);
        stop  = 1'b0;
        pause = 1'b0;

        // Limit 1: latency of first increment and of done
        begin_run(1, 1'b0);
        k = 0;
        do begin
            cycle("t6");
            k++;
        end while (count != 1 && k < 50);
        check("t6_first_tick", k, TK);
        k = 0;
        do begin
            cycle("t6d");
            k++;
        end while (done !== 1'b1 && k < 50);
        check("t6_done_lat", k, TK);

        // Random stimulus
        stop = 1'b1;
        cycle("rnd_init");
        stop = 1'b0;
        repeat (3000) begin
            stop        = ($urandom_range(0, 31) == 0);
            start       = ($urandom_range(0, 3) == 0);
            pause       = ($urandom_range(0, 4) == 0);
            auto_reload = ($urandom_range(0, 1) == 1);
            limit       = W'($urandom);
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
